// File: rtl/usb_in_scheduler.sv
// Services USB IN tokens for EP0/EP1: drains the IN FIFO into a packet buffer, sends PID + payload, tracks DATA0/DATA1.
// Latency: fill takes one cycle per byte; the PID beat follows the fill, and a retransmit or handshake starts one cycle after tok_in.
// Backpressure: tx_data/tx_valid hold until tx_ready; tokens arriving while busy are dropped, so the host retries.
//
// Ports:
//   clk, reset                 clock and synchronous active-low reset
//   tok_in/tok_ep, setup       IN token pulse with its endpoint, SETUP-on-EP0 pulse
//   ep0_zlp                    CPU arms a zero-length packet on EP0
//   epN_q/epN_empty/epN_rdreq  show-ahead endpoint IN FIFOs
//   tx_valid/tx_data/tx_last/tx_ready  byte stream to the SIE transmitter
//   hs_ack, hs_timeout         handshake outcome for the last DATA packet
//   busy                       scheduler is not idle
module usb_in_scheduler #(
  parameter int MAXPKT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tok_in,
  input  logic [3:0] tok_ep,
  input  logic       setup,
  input  logic       ep0_zlp,
  input  logic [7:0] ep0_q,
  input  logic       ep0_empty,
  output logic       ep0_rdreq,
  input  logic [7:0] ep1_q,
  input  logic       ep1_empty,
  output logic       ep1_rdreq,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       tx_last,
  input  logic       tx_ready,
  input  logic       hs_ack,
  input  logic       hs_timeout,
  output logic       busy
);

  localparam int LW = $clog2(MAXPKT) + 1;
  // Buffer address width; at least one bit so MAXPKT=1 still elaborates.
  localparam int AW = (MAXPKT > 1) ? $clog2(MAXPKT) : 1;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [1:0] {IDLE, FILL, SEND, WAIT_HS} state_t;

  state_t          state, state_nxt;
  logic            toggle0, toggle1;
  logic            pending, pend_ep;
  logic            zlp0;
  logic            ep;
  logic            is_hs;        // current packet is a bare NAK/STALL handshake
  logic [7:0]      pid;
  logic [LW-1:0]   len, cnt;
  logic [7:0]      pkt_buf [2**AW];

  logic            tok_sel, tok_ok, tok_empty, idle_to_fill;
  logic [7:0]      tok_data_pid;
  logic            sel_empty, fill_rd, fill_done;
  logic [7:0]      sel_q;
  logic [AW-1:0]   wr_idx, rd_idx;

  assign tok_sel      = tok_ep[0];
  assign tok_ok       = (tok_ep[3:1] == 3'b000);
  assign tok_empty    = tok_sel ? ep1_empty : ep0_empty;
  assign tok_data_pid = (tok_sel ? toggle1 : toggle0) ? PID_DATA1 : PID_DATA0;
  // Only a fresh data packet with bytes waiting goes through FILL.
  assign idle_to_fill = tok_ok && !pending && !tok_empty;

  assign sel_empty = ep ? ep1_empty : ep0_empty;
  assign sel_q     = ep ? ep1_q : ep0_q;
  assign fill_rd   = (state == FILL) && !sel_empty && (len != LW'(MAXPKT));
  assign fill_done = !fill_rd || (len == LW'(MAXPKT - 1));
  assign wr_idx    = AW'(len);
  assign rd_idx    = AW'(cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ep0_rdreq = 1'b0;
    ep1_rdreq = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (tok_in) state_nxt = idle_to_fill ? FILL : SEND;
      end
      FILL: begin
        ep0_rdreq = fill_rd && !ep;
        ep1_rdreq = fill_rd && ep;
        if (fill_done) state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = (cnt == '0) ? pid : pkt_buf[rd_idx];
        tx_last  = is_hs || (cnt == len);
        if (tx_ready && tx_last) state_nxt = is_hs ? IDLE : WAIT_HS;
      end
      WAIT_HS: begin
        if (hs_ack || hs_timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fill_rd) pkt_buf[wr_idx] <= sel_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      toggle0 <= 1'b0;
      toggle1 <= 1'b0;
      pending <= 1'b0;
      pend_ep <= 1'b0;
      zlp0    <= 1'b0;
      ep      <= 1'b0;
      is_hs   <= 1'b0;
      pid     <= 8'h00;
      len     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tok_in) begin
            cnt <= '0;
            if (!tok_ok) begin
              is_hs <= 1'b1;
              pid   <= PID_STALL;
            end else if (pending && (pend_ep == tok_sel)) begin
              // Retransmit: buffer and len untouched, toggle not yet flipped.
              is_hs <= 1'b0;
              ep    <= tok_sel;
              pid   <= tok_data_pid;
            end else if (pending) begin
              // The other endpoint's packet still owns the buffer.
              is_hs <= 1'b1;
              pid   <= PID_NAK;
            end else if (!tok_empty) begin
              is_hs <= 1'b0;
              ep    <= tok_sel;
              len   <= '0;
              pid   <= tok_data_pid;
            end else if (!tok_sel && zlp0) begin
              is_hs <= 1'b0;
              ep    <= 1'b0;
              len   <= '0;
              zlp0  <= 1'b0;
              pid   <= tok_data_pid;
            end else begin
              is_hs <= 1'b1;
              pid   <= PID_NAK;
            end
          end
        end
        FILL: begin
          if (fill_rd) len <= len + 1'b1;
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_last) begin
              if (!is_hs) begin
                pending <= 1'b1;
                pend_ep <= ep;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_HS: begin
          // A timeout leaves pending and the toggle alone so the next IN retransmits.
          if (hs_ack) begin
            pending <= 1'b0;
            if (ep) toggle1 <= ~toggle1;
            else    toggle0 <= ~toggle0;
          end
        end
        default: ;
      endcase
      // SETUP overrides any same-cycle ACK on EP0.
      if (setup) begin
        toggle0 <= 1'b1;
        zlp0    <= 1'b0;
        if (!pend_ep) pending <= 1'b0;
      end
      if (ep0_zlp) zlp0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_in_scheduler.sv
module tb_usb_in_scheduler;

  logic       clk;
  logic       reset;
  logic       tok_in;
  logic [3:0] tok_ep;
  logic       setup;
  logic       ep0_zlp;
  logic [7:0] ep0_q;
  logic       ep0_empty;
  logic       ep0_rdreq;
  logic [7:0] ep1_q;
  logic       ep1_empty;
  logic       ep1_rdreq;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       hs_ack;
  logic       hs_timeout;
  logic       busy;

  usb_in_scheduler #(.MAXPKT(8)) dut (
    .clk(clk), .reset(reset),
    .tok_in(tok_in), .tok_ep(tok_ep), .setup(setup), .ep0_zlp(ep0_zlp),
    .ep0_q(ep0_q), .ep0_empty(ep0_empty), .ep0_rdreq(ep0_rdreq),
    .ep1_q(ep1_q), .ep1_empty(ep1_empty), .ep1_rdreq(ep1_rdreq),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .hs_ack(hs_ack), .hs_timeout(hs_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] f0 [$];
  logic [7:0] f1 [$];
  logic [8:0] sb [$];
  int checks = 0;
  int errors = 0;
  int n_rd0 = 0;
  int n_rd1 = 0;
  int bad_rd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd();
    ep0_empty = (f0.size() == 0);
    ep0_q     = (f0.size() != 0) ? f0[0] : 8'h00;
    ep1_empty = (f1.size() == 0);
    ep1_q     = (f1.size() != 0) ? f1[0] : 8'h00;
  endtask

  task automatic push0(input logic [7:0] b); f0.push_back(b); upd(); endtask
  task automatic push1(input logic [7:0] b); f1.push_back(b); upd(); endtask
  task automatic ex(input logic [7:0] d, input logic l); sb.push_back({l, d}); endtask

  // One clock: monitor at negedge, FIFO model pops and pulse inputs clear just after posedge.
  task automatic tick();
    logic p0, p1;
    logic [8:0] e;
    logic [7:0] dmy;
    @(negedge clk);
    if (ep0_rdreq && f0.size() == 0) bad_rd++;
    if (ep1_rdreq && f1.size() == 0) bad_rd++;
    if (ep0_rdreq && ep1_rdreq) bad_rd++;
    p0 = ep0_rdreq;
    p1 = ep1_rdreq;
    if (tx_valid && tx_ready) begin
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat", 32'({tx_last, tx_data}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (p0 && f0.size() != 0) begin dmy = f0.pop_front(); n_rd0++; end
    if (p1 && f1.size() != 0) begin dmy = f1.pop_front(); n_rd1++; end
    tok_in = 1'b0; setup = 1'b0; ep0_zlp = 1'b0; hs_ack = 1'b0; hs_timeout = 1'b0;
    upd();
  endtask

  task automatic tok(input logic [3:0] e);
    tok_in = 1'b1; tok_ep = e; tick();
  endtask

  task automatic run_pkt();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    chk("pkt_done", 32'(sb.size()), 32'd0);
  endtask

  task automatic ack();     hs_ack = 1'b1;     tick(); endtask
  task automatic timeout(); hs_timeout = 1'b1; tick(); endtask

  initial begin
    int r0, r1, n;
    logic [7:0] held;
    reset = 1'b0; tok_in = 1'b0; tok_ep = 4'd0; setup = 1'b0; ep0_zlp = 1'b0;
    tx_ready = 1'b1; hs_ack = 1'b0; hs_timeout = 1'b0;
    upd();
    tick(); tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_last", 32'(tx_last), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdreq", 32'({ep0_rdreq, ep1_rdreq}), 32'd0);
    reset = 1'b1;
    tick();

    // EP1 three bytes on DATA0, then DATA1 after ACK.
    push1(8'h11); push1(8'h22); push1(8'h33);
    r1 = n_rd1;
    ex(8'hC3, 0); ex(8'h11, 0); ex(8'h22, 0); ex(8'h33, 1);
    tok(4'd1); run_pkt();
    chk("ep1_reads", 32'(n_rd1 - r1), 32'd3);
    chk("busy_wait_hs", 32'(busy), 32'd1);
    ack();
    chk("idle_after_ack", 32'(busy), 32'd0);
    push1(8'h44);
    ex(8'h4B, 0); ex(8'h44, 1);
    tok(4'd1); run_pkt(); ack();

    // EP0 ten bytes: a full packet of eight, then the remaining two on DATA1.
    for (int i = 0; i < 10; i++) push0(8'h50 + 8'(i));
    ex(8'hC3, 0);
    for (int i = 0; i < 8; i++) ex(8'h50 + 8'(i), i == 7);
    tok(4'd0); run_pkt();
    chk("ep0_left", 32'(f0.size()), 32'd2);
    ack();
    ex(8'h4B, 0); ex(8'h58, 0); ex(8'h59, 1);
    tok(4'd0); run_pkt(); ack();

    // Empty endpoint NAKs, unknown endpoint STALLs, no FIFO reads.
    r1 = n_rd1;
    ex(8'h5A, 1); tok(4'd1); run_pkt();
    chk("nak_no_read", 32'(n_rd1 - r1), 32'd0);
    ex(8'h1E, 1); tok(4'd5); run_pkt();
    chk("idle_after_stall", 32'(busy), 32'd0);

    // Timeout then retransmit from the buffer; other endpoint NAKs meanwhile.
    push1(8'hAA); push1(8'hBB);
    ex(8'hC3, 0); ex(8'hAA, 0); ex(8'hBB, 1);
    tok(4'd1); run_pkt(); timeout();
    push1(8'hCC); push1(8'hDD);
    ex(8'h5A, 1); tok(4'd0); run_pkt();
    r1 = n_rd1;
    ex(8'hC3, 0); ex(8'hAA, 0); ex(8'hBB, 1);
    tok(4'd1); run_pkt();
    chk("retx_no_read", 32'(n_rd1 - r1), 32'd0);
    chk("retx_fifo_kept", 32'(f1.size()), 32'd2);
    ack();
    ex(8'h4B, 0); ex(8'hCC, 0); ex(8'hDD, 1);
    tok(4'd1); run_pkt(); ack();

    // SETUP forces DATA1; armed ZLP goes out as a single PID beat.
    setup = 1'b1; tick();
    ep0_zlp = 1'b1; tick();
    ex(8'h4B, 1); tok(4'd0); run_pkt(); ack();
    push0(8'h77);
    ex(8'hC3, 0); ex(8'h77, 1);
    tok(4'd0); run_pkt(); ack();

    // Backpressure mid-packet holds the current beat.
    for (int i = 1; i <= 5; i++) push1(8'(i));
    ex(8'hC3, 0);
    for (int i = 1; i <= 5; i++) ex(8'(i), i == 5);
    tok(4'd1);
    n = 0;
    while (sb.size() > 4 && n < 100) begin tick(); n++; end
    tx_ready = 1'b0;
    held = tx_data;
    chk("stall_beat", 32'(held), 32'h02);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(tx_valid), 32'd1);
      chk("stall_data", 32'(tx_data), 32'(held));
    end
    tx_ready = 1'b1;
    run_pkt(); ack();

    // Reset while in SEND abandons the packet and clears the toggles.
    tx_ready = 1'b0;
    push0(8'hE1); push0(8'hE2);
    tok(4'd0);
    n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    chk("reached_send", 32'(tx_valid), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_outputs", 32'({tx_valid, tx_last, tx_data, ep0_rdreq, ep1_rdreq, busy}), 32'd0);
    reset = 1'b1;
    tx_ready = 1'b1;
    sb.delete();
    tick();
    push0(8'h9A);
    ex(8'hC3, 0); ex(8'h9A, 1);
    tok(4'd0); run_pkt(); ack();
    push1(8'h9B);
    ex(8'hC3, 0); ex(8'h9B, 1);
    tok(4'd1); run_pkt(); ack();

    chk("rdreq_legal", 32'(bad_rd), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_in_scheduler.md
Name: usb_in_scheduler

Overview:
- Services USB IN tokens for endpoints 0 and 1 by draining the endpoint IN FIFOs that the J1 CPU fills through its I/O registers.
- Packetizes up to MAXPKT bytes per transaction, sends them to the SIE transmitter as a byte stream, and tracks the DATA0/DATA1 toggle per endpoint.
- Keeps the last packet in a local buffer so it can be retransmitted if no ACK arrives.
- Sits between the endpoint FIFOs and the SIE; the CPU-side FIFO interface is unchanged.

Parameters:
MAXPKT, 8, maximum payload bytes per IN packet (1..64)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tok_in  in  1  one-cycle pulse: IN token received and addressed to this device
tok_ep  in  4  endpoint number of the token, valid with tok_in
setup  in  1  one-cycle pulse: SETUP token on EP0 received
ep0_zlp  in  1  one-cycle pulse from CPU: arm zero-length packet on EP0
ep0_q  in  8  EP0 IN FIFO head byte (show-ahead)
ep0_empty  in  1  EP0 IN FIFO empty
ep0_rdreq  out  1  pop EP0 IN FIFO
ep1_q  in  8  EP1 IN FIFO head byte (show-ahead)
ep1_empty  in  1  EP1 IN FIFO empty
ep1_rdreq  out  1  pop EP1 IN FIFO
tx_valid  out  1  tx_data valid
tx_data  out  8  PID byte, then payload bytes
tx_last  out  1  final beat of packet
tx_ready  in  1  SIE accepts beat when tx_valid and tx_ready
hs_ack  in  1  one-cycle pulse: host ACK received
hs_timeout  in  1  one-cycle pulse: handshake timeout
busy  out  1  state is not IDLE

Behaviour:
- Reset (reset low at a clk edge):
  - all outputs 0; state IDLE.
  - toggle0 = toggle1 = 0 (DATA0); pending = 0; zlp0 = 0; buffer length 0.
- A mid-operation reset abandons the packet. FIFO bytes already popped are lost.
- PID bytes are {~pid, pid}: DATA0 8'hC3, DATA1 8'h4B, NAK 8'h5A, STALL 8'h1E.
- States: IDLE, FILL, SEND, WAIT_HS.
- IDLE: tok_in is sampled only in IDLE. Tokens in other states are ignored. Decisions, first match wins:
  - tok_ep not 0 or 1 -> queue STALL, go to SEND.
  - pending=1 and pend_ep==tok_ep -> retransmit the buffer with the same toggle, go to SEND. No FIFO reads.
  - pending=1 and pend_ep!=tok_ep -> queue NAK, go to SEND.
  - FIFO of tok_ep not empty -> latch ep, len=0, go to FILL.
  - tok_ep==0 and zlp0=1 -> len=0, clear zlp0, queue DATAx with no payload, go to SEND.
  - otherwise -> queue NAK, go to SEND.
- FILL:
  - Each cycle with FIFO not empty and len<MAXPKT: capture q into buf[len], assert rdreq for that cycle, len+=1.
  - Leave for SEND when the FIFO is empty or len==MAXPKT. Empty in the same cycle as the last read is fine.
  - Latency: len+1 cycles from tok_in to first tx_valid.
- SEND:
  - Beat 0 is the PID byte; then buf[0..len-1].
  - tx_data/tx_valid are held stable until tx_ready.
  - tx_last is asserted on the final beat: the PID beat when len=0 or the packet is NAK/STALL.
  - After the last beat is accepted: NAK/STALL -> IDLE; DATA -> WAIT_HS with pending=1, pend_ep=ep.
- WAIT_HS:
  - hs_ack -> flip toggle[ep], pending=0, go to IDLE.
  - hs_timeout -> keep pending=1 and the toggle, go to IDLE. The next IN to the same ep retransmits.
  - hs_ack and hs_timeout in the same cycle -> ack wins.
- setup, in any state:
  - sets toggle0=1 (the next data/status stage is DATA1).
  - clears pending if pend_ep==0, and clears zlp0.
  - If it coincides with hs_ack for ep0, toggle0=1 (setup wins).
- ep0_zlp sets zlp0 in any state. A non-empty EP0 FIFO takes precedence over zlp0; zlp0 stays armed.
- Each rdreq is asserted only while its own FIFO is not empty and only in FILL. It is never asserted for the other endpoint.
- len is log2(MAXPKT)+1 bits wide and never exceeds MAXPKT.

Test Plan:
- Reset, then EP1 FIFO holds 3 bytes 11,22,33; tok_in ep1 -> stream C3,11,22,33 with tx_last on 33, ep1_rdreq pulsed 3 times. hs_ack -> next packet PID 4B.
- EP0 FIFO holds 10 bytes, MAXPKT=8; IN ep0 -> 8 data bytes, 2 remain in FIFO. ACK, then IN -> PID 4B plus 2 bytes.
- IN ep1 with empty FIFO -> single beat 5A with tx_last, no rdreq. IN ep5 -> single beat 1E.
- EP1 packet AA,BB sent, then hs_timeout, then 2 more bytes written; IN ep1 -> identical C3,AA,BB, FIFO untouched. Meanwhile IN ep0 -> 5A.
- setup, then ep0_zlp, then IN ep0 with empty FIFO -> single beat 4B with tx_last. hs_ack -> toggle0=0.
- tx_ready held low 5 cycles mid-packet -> tx_data stable throughout. Reset asserted in SEND -> all outputs 0 the next cycle, toggles cleared.
